pwm_multi_timer: RTL and testbench

PWM_MULTI_TIMER -- requirements
Module: pwm_multi_timer

---
 rtl/pwm_timer_pkg.sv | 46 ++++
 rtl/pwm_multi_timer_if.sv | 20 ++
 rtl/pwm_channel.sv | 122 ++++++++++++
 rtl/pwm_multi_timer.sv | 111 +++++++++++
 tb/tb_pwm_multi_timer.sv | 267 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_timer_pkg.sv
// Shared constants for the multi-channel PWM/timer block: register
// offsets inside a channel window, CTRL bit positions and the channel stride.
package pwm_timer_pkg;

  // Byte distance between two consecutive channel register windows
  localparam int unsigned CH_STRIDE = 8;

  // Byte offsets of the registers inside one channel window
  localparam logic [2:0] OFF_CTRL     = 3'd0;
  localparam logic [2:0] OFF_PRESCALE = 3'd2;
  localparam logic [2:0] OFF_PERIOD   = 3'd4;
  localparam logic [2:0] OFF_DUTY     = 3'd6;

  // CTRL bit positions; everything above CTRL_POL reads back as zero
  localparam int CTRL_EN   = 0;
  localparam int CTRL_MODE = 1;
  localparam int CTRL_CONT = 2;
  localparam int CTRL_IE   = 3;
  localparam int CTRL_POL  = 4;
  localparam int CTRL_W    = 5;

  typedef enum logic [1:0] {
    REG_CTRL     = 2'd0,
    REG_PRESCALE = 2'd1,
    REG_PERIOD   = 2'd2,
    REG_DUTY     = 2'd3
  } reg_sel_e;

  typedef enum logic {
    MODE_TIMER = 1'b0,
    MODE_PWM   = 1'b1
  } mode_e;

  // Map an aligned in-window byte offset to the register it addresses
  function automatic reg_sel_e offset_to_reg(input logic [2:0] off);
    reg_sel_e sel;
    case (off)
      OFF_PRESCALE: sel = REG_PRESCALE;
      OFF_PERIOD:   sel = REG_PERIOD;
      OFF_DUTY:     sel = REG_DUTY;
      default:      sel = REG_CTRL;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/pwm_multi_timer_if.sv
// Wishbone classic slave bus bundle used by pwm_multi_timer.
interface pwm_multi_timer_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [15:0] adr;
  logic [15:0] wr_data;
  logic [15:0] rd_data;
  logic        ack;

  modport master (
    output cyc, stb, we, adr, wr_data,
    input  rd_data, ack
  );

  modport slave (
    input  cyc, stb, we, adr, wr_data,
    output rd_data, ack
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM/timer channel: control and prescale registers, shadowed
// period/duty, prescaler, main counter, registered output and irq pulse.
module pwm_channel
  import pwm_timer_pkg::*;
#(
  parameter int CW = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl_we,
  input  logic              prescale_we,
  input  logic              period_we,
  input  logic              duty_we,
  input  logic [15:0]       wr_data,
  output logic [CTRL_W-1:0] ctrl,
  output logic [CW-1:0]     prescale,
  output logic [CW-1:0]     period_shadow,
  output logic [CW-1:0]     duty_shadow,
  output logic              pwm,
  output logic              irq_pulse
);

  logic [CW-1:0] pre_cnt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] period_act;
  logic [CW-1:0] duty_act;

  logic  en;
  logic  cont;
  logic  pol;
  mode_e mode;

  logic mode_restart;
  logic tick;
  logic pwm_wrap;
  logic timer_expire;
  logic load_active;
  logic raw;

  assign en   = ctrl[CTRL_EN];
  assign cont = ctrl[CTRL_CONT];
  assign pol  = ctrl[CTRL_POL];
  assign mode = mode_e'(ctrl[CTRL_MODE]);

  // Tick, wrap/expiry detection, raw waveform and interrupt pulse
  always_comb begin
    mode_restart = ctrl_we && en && (wr_data[CTRL_MODE] != ctrl[CTRL_MODE]);
    tick         = en && (pre_cnt >= prescale);
    pwm_wrap     = 1'b0;
    timer_expire = 1'b0;
    raw          = 1'b0;
    if (mode == MODE_PWM) begin
      pwm_wrap = tick && ((period_act == '0) ||
                 (({1'b0, cnt} + (CW+1)'(1)) >= {1'b0, period_act}));
      raw      = en && (period_act != '0) && (cnt < duty_act);
    end else begin
      timer_expire = tick && (cnt >= period_act);
      raw          = timer_expire;
    end
    load_active = !en || pwm_wrap || timer_expire;
    irq_pulse   = timer_expire || (pwm_wrap && (period_act != '0));
  end

  // Control register; a bus write beats the one-shot auto-disable
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl <= '0;
    end else if (ctrl_we) begin
      ctrl <= wr_data[CTRL_W-1:0];
    end else if (timer_expire && !cont) begin
      ctrl[CTRL_EN] <= 1'b0;
    end
  end

  // Bus-visible prescale value and period/duty shadows
  always_ff @(posedge clk) begin
    if (rst) begin
      prescale      <= '0;
      period_shadow <= '0;
      duty_shadow   <= '0;
    end else begin
      if (prescale_we) prescale      <= wr_data[CW-1:0];
      if (period_we)   period_shadow <= wr_data[CW-1:0];
      if (duty_we)     duty_shadow   <= wr_data[CW-1:0];
    end
  end

  // Active period/duty follow the shadows while idle or at a counter wrap
  always_ff @(posedge clk) begin
    if (rst) begin
      period_act <= '0;
      duty_act   <= '0;
    end else if (load_active) begin
      period_act <= period_shadow;
      duty_act   <= duty_shadow;
    end
  end

  // Prescaler and main counter, held at zero while disabled or on mode change
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else if (!en || mode_restart) begin
      pre_cnt <= '0;
      cnt     <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + CW'(1);
      if (tick) begin
        if (pwm_wrap || timer_expire) cnt <= '0;
        else                          cnt <= cnt + CW'(1);
      end
    end
  end

  // Registered output with optional polarity inversion
  always_ff @(posedge clk) begin
    if (rst) pwm <= 1'b0;
    else     pwm <= raw ^ pol;
  end

endmodule

// File: rtl/pwm_multi_timer.sv
// Multi-channel PWM/timer: Wishbone decode, IRQ status register and read mux
// around N_CH pwm_channel instances.
module pwm_multi_timer
  import pwm_timer_pkg::*;
#(
  parameter int          N_CH     = 4,
  parameter int          CW       = 16,
  parameter logic [15:0] BASE_ADR = 16'h0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  pwm_multi_timer_if.slave   wb,
  output logic [N_CH-1:0]    o_pwm,
  output logic               o_irq
);

  localparam logic [15:0] IRQ_OFF = 16'(CH_STRIDE * N_CH);

  logic [15:0]     offset;
  logic            req;
  logic            wr_req;
  logic [2:0]      ch_idx;
  logic            sel_valid;
  logic            sel_irq;
  reg_sel_e        sel_reg;
  logic [15:0]     rd_mux;
  logic [N_CH-1:0] w1c;

  logic [N_CH-1:0] irq_stat;
  logic [N_CH-1:0] ch_hit;
  logic [N_CH-1:0] ch_irq;
  logic [N_CH-1:0] ch_ie;

  logic [CTRL_W-1:0] ch_ctrl     [N_CH];
  logic [CW-1:0]     ch_prescale [N_CH];
  logic [CW-1:0]     ch_period   [N_CH];
  logic [CW-1:0]     ch_duty     [N_CH];

  // Address decode relative to the base; odd addresses are treated as unmapped
  always_comb begin
    offset    = wb.adr - BASE_ADR;
    req       = wb.cyc && wb.stb && !wb.ack;
    wr_req    = req && wb.we;
    ch_idx    = offset[5:3];
    sel_irq   = (offset == IRQ_OFF);
    sel_valid = (offset < IRQ_OFF) && !offset[0];
    sel_reg   = offset_to_reg(offset[2:0]);
    w1c       = (wr_req && sel_irq) ? wb.wr_data[N_CH-1:0] : '0;
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    assign ch_hit[g] = wr_req && sel_valid && (ch_idx == 3'(g));
    assign ch_ie[g]  = ch_ctrl[g][CTRL_IE];

    pwm_channel #(.CW(CW)) u_channel (
      .clk           (i_clk),
      .rst           (i_rst),
      .ctrl_we       (ch_hit[g] && (sel_reg == REG_CTRL)),
      .prescale_we   (ch_hit[g] && (sel_reg == REG_PRESCALE)),
      .period_we     (ch_hit[g] && (sel_reg == REG_PERIOD)),
      .duty_we       (ch_hit[g] && (sel_reg == REG_DUTY)),
      .wr_data       (wb.wr_data),
      .ctrl          (ch_ctrl[g]),
      .prescale      (ch_prescale[g]),
      .period_shadow (ch_period[g]),
      .duty_shadow   (ch_duty[g]),
      .pwm           (o_pwm[g]),
      .irq_pulse     (ch_irq[g])
    );
  end

  // Read data selection; anything unmapped reads as zero
  always_comb begin
    rd_mux = '0;
    if (sel_irq) begin
      rd_mux = 16'(irq_stat);
    end else if (sel_valid) begin
      for (int i = 0; i < N_CH; i++) begin
        if (ch_idx == 3'(i)) begin
          case (sel_reg)
            REG_CTRL:     rd_mux = 16'(ch_ctrl[i]);
            REG_PRESCALE: rd_mux = 16'(ch_prescale[i]);
            REG_PERIOD:   rd_mux = 16'(ch_period[i]);
            REG_DUTY:     rd_mux = 16'(ch_duty[i]);
            default:      rd_mux = '0;
          endcase
        end
      end
    end
  end

  // Single-cycle acknowledge with registered read data; reset drops the cycle
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wb.ack     <= 1'b0;
      wb.rd_data <= '0;
    end else begin
      wb.ack     <= req;
      wb.rd_data <= (req && !wb.we) ? rd_mux : '0;
    end
  end

  // Sticky interrupt status; a hardware set beats a same-cycle clear
  always_ff @(posedge i_clk) begin
    if (i_rst) irq_stat <= '0;
    else       irq_stat <= (irq_stat & ~w1c) | ch_irq;
  end

  assign o_irq = |(irq_stat & ch_ie);

endmodule

// File: tb/tb_pwm_multi_timer.sv
// Self-checking bench for pwm_multi_timer: directed register/IRQ/reset steps
// plus randomized channel configurations against an arithmetic model.
module tb_pwm_multi_timer;

  localparam int          N_CH    = 4;
  localparam int          CW      = 16;
  localparam logic [15:0] IRQ_ADR = 16'h0020;
  localparam logic [15:0] UNMAP   = 16'h0030;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N_CH-1:0] pwm;
  logic            irq;
  int              checks = 0;
  int              errors = 0;
  int              cyc_count = 0;

  pwm_multi_timer_if bus ();

  pwm_multi_timer #(.N_CH(N_CH), .CW(CW), .BASE_ADR(16'h0000)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .wb    (bus),
    .o_pwm (pwm),
    .o_irq (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc_count <= cyc_count + 1;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic apply_stimulus(input logic write, input logic [15:0] adr,
                                input logic [15:0] data, output logic [15:0] rdata,
                                output int ack_cycle);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = write;
    bus.adr = adr;  bus.wr_data = data;
    do begin
      @(posedge clk); #1;
      waited++;
    end while (bus.ack !== 1'b1 && waited < 8);
    if (bus.ack !== 1'b1) check_output("ack_timeout", 32'd0, 32'd1);
    rdata     = bus.rd_data;
    ack_cycle = cyc_count;
    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
  endtask

  task automatic bus_write(input logic [15:0] adr, input logic [15:0] data);
    logic [15:0] dummy;
    int          ac;
    apply_stimulus(1'b1, adr, data, dummy, ac);
  endtask

  task automatic bus_read(input logic [15:0] adr, output logic [15:0] data, output int ac);
    apply_stimulus(1'b0, adr, 16'h0000, data, ac);
  endtask

  // Output seen j edges after the enabling write, from tick arithmetic
  function automatic logic model_out(int j, int p, int t, int d,
                                     logic mode, logic cont, logic pol);
    int   k;
    int   ticks;
    logic raw;
    k     = j - 1;
    ticks = k / (p + 1);
    raw   = 1'b0;
    if (mode) begin
      raw = (t != 0) && ((ticks % t) < d);
    end else if ((k % (p + 1)) == p) begin
      if (cont) raw = ((ticks % (t + 1)) == t);
      else      raw = (ticks == t);
    end
    return raw ^ pol;
  endfunction

  // Edge (relative to enable) at which the channel first sets its IRQ bit
  function automatic int first_irq(int p, int t, logic mode);
    if (mode) return (t == 0) ? -1 : t * (p + 1);
    return (t + 1) * (p + 1);
  endfunction

  task automatic run_trial(input int ch, input int p, input int t, input int d,
                           input logic [4:0] ctrl, input int n);
    logic [15:0] rdv;
    logic [15:0] base;
    logic [31:0] exp_ctrl;
    int          e0, ac, j, f;
    logic        mode, cont, ie, pol;
    mode = ctrl[1]; cont = ctrl[2]; ie = ctrl[3]; pol = ctrl[4];
    base = 16'(ch * 8);
    bus_write(base, 16'h0000);
    bus_write(base + 16'd2, 16'(p));
    bus_write(base + 16'd4, 16'(t));
    bus_write(base + 16'd6, 16'(d));
    bus_write(IRQ_ADR, 16'h00FF);
    apply_stimulus(1'b1, base, 16'(ctrl), rdv, e0);
    f = first_irq(p, t, mode);
    for (int i = 1; i <= n; i++) begin
      @(posedge clk); #1;
      j = cyc_count - e0;
      check_output($sformatf("pwm_ch%0d_j%0d", ch, j), 32'(pwm),
                   32'(model_out(j, p, t, d, mode, cont, pol)) << ch);
    end
    bus_read(IRQ_ADR, rdv, ac);
    j = ac - e0;
    check_output($sformatf("irq_stat_ch%0d", ch), 32'(rdv),
                 (f >= 0 && j - 1 >= f) ? (32'd1 << ch) : 32'd0);
    check_output($sformatf("o_irq_ch%0d", ch), 32'(irq),
                 32'(f >= 0 && j >= f && ie));
    bus_read(base, rdv, ac);
    j = ac - e0;
    exp_ctrl = 32'(ctrl);
    if (!mode && !cont && j - 1 >= f) exp_ctrl = exp_ctrl & ~32'd1;
    check_output($sformatf("ctrl_rb_ch%0d", ch), 32'(rdv), exp_ctrl);
    bus_write(base, 16'h0000);
  endtask

  initial begin
    logic [15:0] rdv;
    int          ac, e0, jw, sw, j, dd;

    bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
    bus.adr = '0;   bus.wr_data = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_output("rst_ack", 32'(bus.ack), 32'd0);
    check_output("rst_rdata", 32'(bus.rd_data), 32'd0);
    check_output("rst_pwm", 32'(pwm), 32'd0);
    check_output("rst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a <= 32; a += 2) begin
      bus_read(16'(a), rdv, ac);
      check_output($sformatf("rst_reg_%0h", a), 32'(rdv), 32'd0);
    end

    // Register readback, CTRL upper bits, unmapped addresses
    bus_write(16'h0018, 16'hFFE0);
    bus_read(16'h0018, rdv, ac);
    check_output("ctrl_upper_bits", 32'(rdv), 32'h0000);
    bus_write(16'h001A, 16'hABCD);
    bus_read(16'h001A, rdv, ac);
    check_output("prescale_rb", 32'(rdv), 32'hABCD);
    bus_write(16'h001C, 16'h1234);
    bus_read(16'h001C, rdv, ac);
    check_output("period_rb", 32'(rdv), 32'h1234);
    bus_write(16'h001E, 16'h00FF);
    bus_read(16'h001E, rdv, ac);
    check_output("duty_rb", 32'(rdv), 32'h00FF);
    bus_write(16'h001A, 16'h0000);
    bus_write(16'h001C, 16'h0000);
    bus_write(16'h001E, 16'h0000);
    bus_write(16'h0022, 16'hFFFF);
    bus_read(16'h0022, rdv, ac);
    check_output("unmapped_rd", 32'(rdv), 32'h0000);
    bus_read(IRQ_ADR, rdv, ac);
    check_output("unmapped_wr_no_irq", 32'(rdv), 32'h0000);

    // PWM 3/10, one-shot timer, duty boundaries with and without inversion
    run_trial(0, 0, 10, 3, 5'h03, 40);
    run_trial(1, 1, 4, 0, 5'h09, 30);
    run_trial(2, 0, 10, 0, 5'h03, 25);
    run_trial(2, 0, 10, 12, 5'h03, 25);
    run_trial(2, 0, 10, 0, 5'h13, 25);
    run_trial(2, 0, 10, 12, 5'h13, 25);

    // Duty change in mid-period takes effect from the next period
    bus_write(16'h0002, 16'd0);
    bus_write(16'h0004, 16'd10);
    bus_write(16'h0006, 16'd3);
    apply_stimulus(1'b1, 16'h0000, 16'h0003, rdv, e0);
    repeat (12) @(posedge clk);
    apply_stimulus(1'b1, 16'h0006, 16'd7, rdv, ac);
    jw = ac - e0;
    sw = (jw / 10 + 1) * 10;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      j  = cyc_count - e0;
      dd = (j - 1 >= sw) ? 7 : 3;
      check_output($sformatf("duty_update_j%0d", j), 32'(pwm),
                   32'(((j - 1) % 10) < dd));
    end
    bus_write(16'h0000, 16'h0000);

    // W1C colliding with a hardware set keeps the bit; clearing a clear bit is harmless
    bus_write(16'h000A, 16'd1);
    bus_write(16'h000C, 16'd4);
    bus_write(IRQ_ADR, 16'h00FF);
    apply_stimulus(1'b1, 16'h0008, 16'h000D, rdv, e0);
    repeat (9) @(posedge clk);
    apply_stimulus(1'b1, IRQ_ADR, 16'h0002, rdv, ac);
    check_output("w1c_collision_edge", 32'(ac - e0), 32'd10);
    bus_read(IRQ_ADR, rdv, ac);
    check_output("w1c_collision_kept", 32'(rdv), 32'h0002);
    check_output("w1c_collision_irq", 32'(irq), 32'd1);
    bus_write(IRQ_ADR, 16'h0001);
    bus_read(IRQ_ADR, rdv, ac);
    check_output("w1c_clear_bit_noop", 32'(rdv), 32'h0002);
    bus_write(16'h0008, 16'h0000);
    bus_write(IRQ_ADR, 16'h0002);
    bus_read(IRQ_ADR, rdv, ac);
    check_output("w1c_cleared", 32'(rdv), 32'h0000);
    check_output("w1c_irq_low", 32'(irq), 32'd0);

    // Randomized channel configurations
    for (int r = 0; r < 10; r++) begin
      run_trial(int'($urandom_range(0, N_CH - 1)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 12)), int'($urandom_range(0, 14)),
                {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1}, 60);
    end

    // Reset in the middle of activity with a bus cycle in flight
    bus_write(16'h0004, 16'd10);  bus_write(16'h0006, 16'd3);
    bus_write(16'h000A, 16'd1);   bus_write(16'h000C, 16'd4);
    bus_write(16'h0014, 16'd5);   bus_write(16'h0016, 16'd2);
    bus_write(16'h001C, 16'd6);   bus_write(16'h001E, 16'd9);
    bus_write(16'h0000, 16'h000B); bus_write(16'h0008, 16'h000D);
    bus_write(16'h0010, 16'h0013); bus_write(16'h0018, 16'h000B);
    repeat (17) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    bus.cyc = 1'b1; bus.stb = 1'b1; bus.we = 1'b0; bus.adr = UNMAP;
    @(posedge clk); #1;
    check_output("midrst_ack", 32'(bus.ack), 32'd0);
    check_output("midrst_rdata", 32'(bus.rd_data), 32'd0);
    check_output("midrst_pwm", 32'(pwm), 32'd0);
    check_output("midrst_irq", 32'(irq), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.cyc = 1'b0; bus.stb = 1'b0;
    @(posedge clk); #1;
    check_output("midrst_dropped_ack", 32'(bus.ack), 32'd0);
    for (int a = 0; a <= 32; a += 2) begin
      bus_read(16'(a), rdv, ac);
      check_output($sformatf("midrst_reg_%0h", a), 32'(rdv), 32'd0);
    end
    bus_read(UNMAP, rdv, ac);
    check_output("midrst_unmapped", 32'(rdv), 32'd0);
    @(posedge clk); #1;
    check_output("ack_one_cycle", 32'(bus.ack), 32'd0);
    check_output("final_pwm", 32'(pwm), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
